// File: rtl/arcade_input_pkg.sv
// Shared scancodes and coin sequencer states for the arcade input front end.
// Pure declarations; no logic and no latency.
package arcade_input_pkg;

  // Arrow keys match on the low byte only, so extended and plain codes alias.
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [8:0] SC_SPACE  = 9'h029;
  localparam logic [8:0] SC_CTRL   = 9'h014;
  localparam logic [8:0] SC_START1 = 9'h005;
  localparam logic [8:0] SC_START2 = 9'h006;
  localparam logic [8:0] SC_COIN   = 9'h004;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_GAP
  } coin_state_t;

endpackage

// File: rtl/arcade_input_ctrl_coin_pulser.sv
// Coin pulse shaper: fixed-width high pulse, enforced low gap, one queued request.
// coin rises 1 cycle after req; requests beyond a single pending one are dropped.
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE = 2000000,
  parameter int COIN_GAP   = 2000000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic req,
  output logic coin,
  output logic busy
);

  localparam int CNT_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(COIN_PULSE - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(COIN_GAP - 1);

  coin_state_t   state;
  logic [CW-1:0] cnt;
  logic          pending;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pending <= 1'b0;
      coin    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state <= ST_PULSE;
            cnt   <= '0;
            coin  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (req) pending <= 1'b1;
          if (cnt == PULSE_LAST) begin
            state <= ST_GAP;
            cnt   <= '0;
            coin  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            // A request landing on the expiry cycle counts as already queued.
            if (pending || req) begin
              state   <= ST_PULSE;
              pending <= 1'b0;
              coin    <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
            if (req) pending <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          coin  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Merges PS/2 key events and two pads into registered game controls plus a shaped coin pulse.
// Pads reach outputs in 1 cycle, keys in 2, coin rises 2 cycles after a raw edge; no backpressure.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE = 2000000,
  parameter int COIN_GAP   = 2000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  output logic        m_left,
  output logic        m_right,
  output logic        m_up,
  output logic        m_down,
  output logic        m_fire,
  output logic        m_start1,
  output logic        m_start2,
  output logic        m_coin,
  output logic        coin_busy
);

  logic tog_q, tog_vld;
  logic key_evt;
  logic ku, kd, kl, kr, kf, ks1, ks2, kcoin;
  logic [7:0] j;
  logic c_left, c_right, c_up, c_down, c_fire, c_start1, c_start2;
  logic raw, raw_q, req_r;

  // Pad bits above the coin button carry nothing this core uses.
  logic unused_pad_bits;
  assign unused_pad_bits = ^{joystick_0[15:8], joystick_1[15:8]};

  // tog_vld gates the first post-reset cycle so a stale toggle level is absorbed.
  assign key_evt = tog_vld && (ps2_key[10] != tog_q);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tog_q   <= 1'b0;
      tog_vld <= 1'b0;
      ku      <= 1'b0;
      kd      <= 1'b0;
      kl      <= 1'b0;
      kr      <= 1'b0;
      kf      <= 1'b0;
      ks1     <= 1'b0;
      ks2     <= 1'b0;
      kcoin   <= 1'b0;
    end else begin
      tog_q   <= ps2_key[10];
      tog_vld <= 1'b1;
      if (key_evt) begin
        if (ps2_key[7:0] == SC_UP)    ku <= ps2_key[9];
        if (ps2_key[7:0] == SC_DOWN)  kd <= ps2_key[9];
        if (ps2_key[7:0] == SC_LEFT)  kl <= ps2_key[9];
        if (ps2_key[7:0] == SC_RIGHT) kr <= ps2_key[9];
        if (ps2_key[8:0] == SC_SPACE || ps2_key[8:0] == SC_CTRL) kf <= ps2_key[9];
        if (ps2_key[8:0] == SC_START1) ks1   <= ps2_key[9];
        if (ps2_key[8:0] == SC_START2) ks2   <= ps2_key[9];
        if (ps2_key[8:0] == SC_COIN)   kcoin <= ps2_key[9];
      end
    end
  end

  assign j        = joystick_0[7:0] | joystick_1[7:0];
  assign c_left   = rotate ? (kd | j[2]) : (kl | j[1]);
  assign c_right  = rotate ? (ku | j[3]) : (kr | j[0]);
  assign c_up     = rotate ? (kl | j[1]) : (ku | j[3]);
  assign c_down   = rotate ? (kr | j[0]) : (kd | j[2]);
  assign c_fire   = kf | j[4];
  assign c_start1 = ks1 | j[5];
  assign c_start2 = ks2 | j[6];
  assign raw      = c_start1 | c_start2 | kcoin | j[7];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      m_left   <= 1'b0;
      m_right  <= 1'b0;
      m_up     <= 1'b0;
      m_down   <= 1'b0;
      m_fire   <= 1'b0;
      m_start1 <= 1'b0;
      m_start2 <= 1'b0;
      raw_q    <= 1'b0;
      req_r    <= 1'b0;
    end else begin
      if (tog_vld) begin
        m_left   <= c_left;
        m_right  <= c_right;
        m_up     <= c_up;
        m_down   <= c_down;
        m_fire   <= c_fire;
        m_start1 <= c_start1;
        m_start2 <= c_start2;
      end
      raw_q <= raw;
      req_r <= tog_vld & raw & ~raw_q;
    end
  end

  coin_pulser #(
    .COIN_PULSE(COIN_PULSE),
    .COIN_GAP  (COIN_GAP)
  ) u_coin (
    .clk_sys(clk_sys),
    .reset  (reset),
    .req    (req_r),
    .coin   (m_coin),
    .busy   (coin_busy)
  );

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations, a negedge monitor retires them.
module tb_arcade_input_ctrl;

  localparam logic [8:0] M_LEFT  = 9'h100;
  localparam logic [8:0] M_RIGHT = 9'h080;
  localparam logic [8:0] M_UP    = 9'h040;
  localparam logic [8:0] M_DOWN  = 9'h020;
  localparam logic [8:0] M_FIRE  = 9'h010;
  localparam logic [8:0] M_S1    = 9'h008;
  localparam logic [8:0] M_S2    = 9'h004;
  localparam logic [8:0] M_COIN  = 9'h002;
  localparam logic [8:0] M_BUSY  = 9'h001;
  localparam logic [8:0] M_ALL   = 9'h1FF;
  localparam logic [8:0] M_DIRS  = 9'h1E0;
  localparam logic [8:0] M_CB    = 9'h003;

  typedef struct {
    int         cyc;
    logic [8:0] mask;
    logic [8:0] val;
    string      name;
  } exp_t;

  logic        clk_sys;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic        rotate;
  logic        m_left, m_right, m_up, m_down, m_fire, m_start1, m_start2, m_coin, coin_busy;
  logic [8:0]  obs;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  arcade_input_ctrl #(.COIN_PULSE(4), .COIN_GAP(3)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_key   (ps2_key),
    .joystick_0(joystick_0),
    .joystick_1(joystick_1),
    .rotate    (rotate),
    .m_left    (m_left),
    .m_right   (m_right),
    .m_up      (m_up),
    .m_down    (m_down),
    .m_fire    (m_fire),
    .m_start1  (m_start1),
    .m_start2  (m_start2),
    .m_coin    (m_coin),
    .coin_busy (coin_busy)
  );

  assign obs = {m_left, m_right, m_up, m_down, m_fire, m_start1, m_start2, m_coin, coin_busy};

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        n_cmp++;
        if (sb[i].cyc < cyc || ((obs ^ sb[i].val) & sb[i].mask) != 9'h000) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got %b want %b (mask %b)",
                   sb[i].name, sb[i].cyc, obs & sb[i].mask, sb[i].val, sb[i].mask);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push_exp(input int at, input logic [8:0] mask, input logic [8:0] val,
                          input string nm);
    exp_t e;
    e.cyc  = cyc + at;
    e.mask = mask;
    e.val  = val;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic key(input logic pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000ns, want finished");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    ps2_key    = {1'b1, 1'b1, 9'h029};
    joystick_0 = 16'h0000;
    joystick_1 = 16'h0000;
    rotate     = 1'b0;

    // Reset, then release with a stale pressed-space toggle level that must not fire.
    tick(2);
    push_exp(0, M_ALL, 9'h000, "in_reset");
    reset = 1'b0;
    push_exp(1, M_ALL, 9'h000, "first_after_release");
    for (int k = 2; k <= 4; k++) push_exp(k, M_FIRE | M_CB, 9'h000, "no_fire_on_release");
    tick(5);

    // Key path: 2-cycle latency, [8] ignored on arrows.
    key(1'b1, 9'h075);
    push_exp(1, M_UP, 9'h000, "up_not_yet");
    push_exp(2, M_UP, M_UP, "up_press");
    tick(3);
    key(1'b0, 9'h075);
    push_exp(2, M_UP, 9'h000, "up_release");
    tick(3);
    key(1'b1, 9'h172);
    push_exp(2, M_DIRS, M_DOWN, "down_extended");
    tick(3);
    key(1'b0, 9'h172);
    push_exp(2, M_DIRS, 9'h000, "down_release");
    tick(3);

    // Space and ctrl share fire: space press, ctrl release clears it.
    key(1'b1, 9'h029);
    push_exp(2, M_FIRE, M_FIRE, "fire_space");
    tick(3);
    key(1'b0, 9'h014);
    push_exp(2, M_FIRE, 9'h000, "fire_ctrl_release");
    tick(3);
    key(1'b1, 9'h01C);
    push_exp(2, M_ALL, 9'h000, "ignored_code");
    tick(3);
    ps2_key = {ps2_key[10], 1'b1, 9'h075};
    push_exp(2, M_UP, 9'h000, "no_toggle_no_event");
    tick(3);

    // Pad start1 one-cycle pulse: start1 next cycle, coin cycles 2-5, gap 6-8.
    joystick_1 = 16'h0020;
    push_exp(1, M_S1 | M_CB, M_S1, "start1_pad");
    push_exp(2, M_S1, 9'h000, "start1_drop");
    for (int k = 2; k <= 5; k++) push_exp(k, M_CB, M_CB, "coin_pulse1");
    for (int k = 6; k <= 8; k++) push_exp(k, M_CB, M_BUSY, "coin_gap1");
    push_exp(9, M_CB, 9'h000, "coin_idle1");
    tick(1);
    joystick_1 = 16'h0000;
    tick(10);

    // Three edges inside one pulse: two pulses, three low cycles between.
    joystick_0 = 16'h0020;
    for (int k = 2; k <= 5; k++)   push_exp(k, M_CB, M_CB, "multi_pulse_a");
    for (int k = 6; k <= 8; k++)   push_exp(k, M_CB, M_BUSY, "multi_gap_a");
    for (int k = 9; k <= 12; k++)  push_exp(k, M_CB, M_CB, "multi_pulse_b");
    for (int k = 13; k <= 15; k++) push_exp(k, M_CB, M_BUSY, "multi_gap_b");
    for (int k = 16; k <= 19; k++) push_exp(k, M_CB, 9'h000, "multi_no_third");
    tick(1);
    joystick_0 = 16'h0000;
    tick(1);
    joystick_0 = 16'h0020;
    tick(1);
    joystick_0 = 16'h0000;
    tick(1);
    joystick_0 = 16'h0020;
    tick(1);
    joystick_0 = 16'h0000;
    tick(16);

    // Coin key: latch lands 1 cycle later, so the pulse is one cycle later too.
    key(1'b1, 9'h004);
    push_exp(2, M_COIN, 9'h000, "coin_key_not_yet");
    for (int k = 3; k <= 6; k++) push_exp(k, M_COIN, M_COIN, "coin_key_pulse");
    push_exp(7, M_COIN, 9'h000, "coin_key_end");
    tick(12);
    key(1'b0, 9'h004);
    tick(3);
    key(1'b1, 9'h006);
    push_exp(2, M_S2, M_S2, "start2_key");
    tick(12);
    key(1'b0, 9'h006);
    push_exp(2, M_S2 | M_CB, 9'h000, "start2_key_release");
    tick(3);

    // Direct pad mapping, unrotated then rotated.
    joystick_1 = 16'h0004;
    push_exp(1, M_DIRS, M_DOWN, "pad_down");
    tick(1);
    joystick_1 = 16'h0000;
    joystick_0 = 16'h0011;
    push_exp(1, M_DIRS | M_FIRE, M_RIGHT | M_FIRE, "pad_right_fire");
    tick(1);
    rotate = 1'b1;
    joystick_0 = 16'h0008;
    push_exp(1, M_DIRS, M_RIGHT, "rot_up_to_right");
    tick(1);
    joystick_0 = 16'h0002;
    push_exp(1, M_DIRS, M_UP, "rot_left_to_up");
    tick(1);
    joystick_0 = 16'h0004;
    push_exp(1, M_DIRS, M_LEFT, "rot_down_to_left");
    tick(1);
    joystick_0 = 16'h0001;
    push_exp(1, M_DIRS, M_DOWN, "rot_right_to_down");
    tick(1);
    rotate = 1'b0;
    push_exp(1, M_DIRS, M_RIGHT, "unrotate_right");
    tick(1);
    joystick_0 = 16'h0000;
    tick(3);

    // Reset on the second pulse cycle kills the coin at once and nothing resumes.
    joystick_0 = 16'h0040;
    push_exp(2, M_COIN, M_COIN, "pre_reset_pulse");
    tick(1);
    joystick_0 = 16'h0000;
    tick(2);
    reset = 1'b1;
    push_exp(0, M_ALL, 9'h000, "reset_mid_pulse");
    tick(2);
    push_exp(0, M_ALL, 9'h000, "held_reset");
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) push_exp(k, M_CB, 9'h000, "no_resume");
    tick(12);

    tick(2);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
